// File: rtl/adc_spi_sampler_if.sv
// axi_stream: minimal valid/ready sample stream.
//   data  : sample word, DATA_WIDTH bits
//   valid : source has a word on data
//   ready : sink accepts the word on a clock edge where valid is also high
interface axi_stream #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: drives a CNV-strobed SPI ADC, shifts in one sample MSB
// first and presents it, width-extended, on a valid/ready stream.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   trigger      start-of-conversion request
//   sclk_divider SPI half-period minus one (clock cycles)
//   conv_time    CNV high time minus one (clock cycles)
//   sign_extend  1 = sign-extend sample, 0 = zero-extend
//   miso         serial data from the ADC
//   cnv          conversion-start strobe to the ADC
//   sclk         SPI clock to the ADC, idles low
//   data_out     sample stream (master side)
//   busy         high whenever the FSM is not idle
//   overrun      high in a cycle where trigger is ignored
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for trigger; latches timing/extension settings
// CONVERT | cnv high, counting down conv_time
// SHIFT   | SAMPLE_WIDTH sclk periods, miso captured on each 0->1 edge
// OUTPUT  | sample presented with valid until the sink takes it
module adc_spi_sampler #(
    parameter int SAMPLE_WIDTH    = 12,
    parameter int DATA_PATH_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [7:0] sclk_divider,
    input  logic [7:0] conv_time,
    input  logic       sign_extend,
    input  logic       miso,
    output logic       cnv,
    output logic       sclk,
    axi_stream.master  data_out,
    output logic       busy,
    output logic       overrun
);

    localparam int BW = $clog2(SAMPLE_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              div_q, div_d;
    logic                    sext_q, sext_d;
    logic                    sclk_q, sclk_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_PATH_WIDTH-1:0] ext_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            sext_q  <= 1'b0;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sext_q  <= sext_d;
            sclk_q  <= sclk_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sext_d  = sext_q;
        sclk_d  = sclk_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = CONVERT;
                    cnt_d   = conv_time;
                    div_d   = sclk_divider;
                    sext_d  = sign_extend;
                    shreg_d = '0;
                end
            end
            CONVERT: begin
                if (cnt_q == 8'd0) begin
                    state_d = SHIFT;
                    cnt_d   = div_q;
                    sclk_d  = 1'b0;
                    bit_d   = BW'(SAMPLE_WIDTH - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!sclk_q) begin
                    // miso is taken on the same edge that raises sclk
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[SAMPLE_WIDTH-2:0], miso};
                    cnt_d   = div_q;
                end else begin
                    sclk_d = 1'b0;
                    cnt_d  = div_q;
                    if (bit_q == '0) begin
                        state_d = OUTPUT;
                    end else begin
                        bit_d = bit_q - BW'(1);
                    end
                end
            end
            OUTPUT: begin
                if (data_out.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // shreg only moves in SHIFT, so the word is stable for all of OUTPUT
    always_comb begin
        ext_data = '0;
        ext_data[SAMPLE_WIDTH-1:0] = shreg_q;
        for (int i = SAMPLE_WIDTH; i < DATA_PATH_WIDTH; i++) begin
            ext_data[i] = sext_q & shreg_q[SAMPLE_WIDTH-1];
        end
    end

    assign cnv            = (state_q == CONVERT);
    assign sclk           = sclk_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = trigger & (state_q != IDLE);
    assign data_out.valid = (state_q == OUTPUT);
    assign data_out.data  = ext_data;

endmodule

// File: tb/tb_adc_spi_sampler.sv
module tb_adc_spi_sampler;

    localparam int W  = 12;
    localparam int DW = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger;
    logic [7:0] sclk_divider;
    logic [7:0] conv_time;
    logic       sign_extend;
    logic       miso = 1'b0;
    logic       cnv;
    logic       sclk;
    logic       busy;
    logic       overrun;

    axi_stream #(.DATA_WIDTH(DW)) data_out ();

    adc_spi_sampler #(.SAMPLE_WIDTH(W), .DATA_PATH_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .trigger      (trigger),
        .sclk_divider (sclk_divider),
        .conv_time    (conv_time),
        .sign_extend  (sign_extend),
        .miso         (miso),
        .cnv          (cnv),
        .sclk         (sclk),
        .data_out     (data_out),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [DW-1:0] data;
        int            t;
        int            ct;
        int            d;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   nsamples = 0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ADC model: presents the next bit after every sclk rise, MSB ready during CNV
    logic [W-1:0] cur_pat = '0;
    int           bit_idx = 0;
    logic         sclk_prev_m = 1'b0;
    always @(posedge clock) begin
        #1;
        if (cnv) begin
            bit_idx = 0;
            miso    = cur_pat[W-1];
        end else if (sclk && !sclk_prev_m) begin
            bit_idx++;
            miso = (bit_idx < W) ? cur_pat[W-1-bit_idx] : 1'b0;
        end
        sclk_prev_m = sclk;
    end

    // monitor / scoreboard
    logic          pv = 1'b0, cnv_p = 1'b0, sclk_p = 1'b0, chk_idle = 1'b0;
    int            first_cyc = 0, cnv_start = 0, sclk_last = -1, sclk_n = 0;
    logic [DW-1:0] held = '0;
    always @(negedge clock) begin
        if (!reset) begin
            pv = 1'b0; chk_idle = 1'b0; cnv_p = 1'b0; sclk_p = 1'b0;
            sclk_n = 0; sclk_last = -1;
        end else begin
            if (chk_idle) begin
                check("valid_low_after_hs", int'(data_out.valid), 0);
                check("busy_low_after_hs", int'(busy), 0);
                chk_idle = 1'b0;
            end
            if (cnv && !cnv_p) begin
                cnv_start = cyc; sclk_n = 0; sclk_last = -1;
                if (exp_q.size() > 0) check("cnv_start_cycle", cyc, exp_q[0].t + 1);
            end
            if (!cnv && cnv_p && exp_q.size() > 0)
                check("cnv_high_cycles", cyc - cnv_start, exp_q[0].ct + 1);
            if (sclk && !sclk_p) begin
                if (sclk_last >= 0 && exp_q.size() > 0)
                    check("sclk_period", cyc - sclk_last, 2 * (exp_q[0].d + 1));
                sclk_last = cyc;
                sclk_n++;
            end
            if (data_out.valid) begin
                if (!pv) begin
                    first_cyc = cyc;
                    held = data_out.data;
                end else begin
                    check("data_stable", int'(data_out.data), int'(held));
                end
                if (data_out.ready) begin
                    nsamples++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("valid_cycle", first_cyc, e.t + 2 + e.ct + 2 * W * (e.d + 1));
                        check("data", int'(data_out.data), int'(e.data));
                        check("sclk_pulses", sclk_n, W);
                    end
                    chk_idle = 1'b1;
                    pv = 1'b0;
                end else begin
                    pv = 1'b1;
                end
            end
            cnv_p  = cnv;
            sclk_p = sclk;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [W-1:0] pat, input int d, input int ct,
                         input logic se, input logic [DW-1:0] expd);
        cur_pat      = pat;
        sclk_divider = 8'(d);
        conv_time    = 8'(ct);
        sign_extend  = se;
        trigger      = 1'b1;
        exp_q.push_back('{expd, cyc, ct, d});
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("sample_delivered", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!data_out.valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_reached", int'(data_out.valid), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cnv"},     int'(cnv), 0);
        check({tag, "_sclk"},    int'(sclk), 0);
        check({tag, "_valid"},   int'(data_out.valid), 0);
        check({tag, "_data"},    int'(data_out.data), 0);
        check({tag, "_busy"},    int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    typedef struct {
        logic [W-1:0]  pat;
        int            d;
        int            ct;
        logic          se;
        logic [DW-1:0] expd;
    } vec_t;

    vec_t vecs[5] = '{
        '{12'hA5C, 0, 3, 1'b1, 16'hFA5C},
        '{12'hA5C, 0, 3, 1'b0, 16'h0A5C},
        '{12'hA5C, 2, 3, 1'b1, 16'hFA5C},
        '{12'h3C5, 1, 0, 1'b1, 16'h03C5},
        '{12'hFFF, 0, 7, 1'b0, 16'h0FFF}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b0; trigger = 1'b1; sclk_divider = '0; conv_time = '0;
        sign_extend = 1'b0; data_out.ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        trigger = 1'b0;
        reset = 1'b1;
        tick(); tick();

        foreach (vecs[i]) begin
            start(vecs[i].pat, vecs[i].d, vecs[i].ct, vecs[i].se, vecs[i].expd);
            wait_done(400);
        end

        // sink stall
        data_out.ready = 1'b0;
        start(12'h801, 0, 3, 1'b1, 16'hF801);
        wait_valid(100);
        for (int i = 0; i < 20; i++) begin
            check("stall_valid_held", int'(data_out.valid), 1);
            check("stall_data_held", int'(data_out.data), 16'hF801);
            tick();
        end
        data_out.ready = 1'b1;
        wait_done(10);

        // ignored triggers in every busy state
        base = nsamples;
        data_out.ready = 1'b0;
        start(12'h5A3, 1, 3, 1'b0, 16'h05A3);
        trigger = 1'b1; #2;
        check("overrun_convert", int'(overrun), 1);
        tick(); trigger = 1'b0; #2;
        check("overrun_clears", int'(overrun), 0);
        repeat (10) tick();
        trigger = 1'b1; #2;
        check("overrun_shift", int'(overrun), 1);
        tick(); trigger = 1'b0;
        wait_valid(200);
        trigger = 1'b1; #2;
        check("overrun_output", int'(overrun), 1);
        tick(); trigger = 1'b0;
        check("output_held_after_trigger", int'(data_out.valid), 1);
        tick();
        data_out.ready = 1'b1;
        wait_done(10);
        repeat (40) tick();
        check("single_sample_after_overruns", nsamples - base, 1);

        // reset mid-SHIFT (around bit 6)
        start(12'hA5C, 0, 3, 1'b1, 16'hFA5C);
        repeat (16) tick();
        check("busy_before_reset", int'(busy), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        base = nsamples;
        repeat (3) tick();
        reset = 1'b1;
        repeat (40) tick();
        check("no_sample_after_abort", nsamples - base, 0);
        start(12'hA5C, 0, 3, 1'b1, 16'hFA5C);
        wait_done(200);

        // settings changed mid-conversion
        start(12'hA5C, 0, 3, 1'b1, 16'hFA5C);
        repeat (8) tick();
        sclk_divider = 8'd5;
        conv_time    = 8'd9;
        sign_extend  = 1'b0;
        wait_done(200);
        start(12'hA5C, 5, 3, 1'b1, 16'hFA5C);
        wait_done(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12: number of bits shifted in per conversion, MSB first.
REQ-002 SHALL have parameter DATA_PATH_WIDTH, default 16: output stream data width; SHALL be >= SAMPLE_WIDTH.
REQ-003 SHALL have ports, one per line:
 clock  input  1  single system clock; all logic on its rising edge
 reset  input  1  asynchronous, active-low reset
 trigger  input  1  start-of-conversion request, sampled each clock
 sclk_divider  input  8  SPI half-period minus one, in clock cycles
 conv_time  input  8  CNV high time minus one, in clock cycles
 sign_extend  input  1  1 = sign-extend sample to DATA_PATH_WIDTH, 0 = zero-extend
 miso  input  1  serial data from ADC
 cnv  output  1  ADC conversion-start strobe
 sclk  output  1  SPI clock to ADC, idles low
 data_out  axi_stream.master  DATA_PATH_WIDTH  sample stream (data, valid, ready) feeding the ADC processing chain
 busy  output  1  high whenever state is not IDLE
 overrun  output  1  one-cycle pulse when a trigger is dropped

Function
REQ-004 SHALL implement FSM states IDLE, CONVERT, SHIFT, OUTPUT.
REQ-005 IDLE: trigger=1 at cycle T SHALL move to CONVERT; cnv SHALL be high from T+1 for exactly conv_time+1 cycles.
REQ-006 CONVERT -> SHIFT on the cycle cnv drops; cnv SHALL be low in all states but CONVERT.
REQ-007 SHIFT: sclk SHALL be low for sclk_divider+1 cycles, then high for sclk_divider+1 cycles, repeated exactly SAMPLE_WIDTH times.
REQ-008 miso SHALL be captured into a shift register on the clock edge where sclk goes 0->1; first captured bit is the sample MSB.
REQ-009 After the final sclk high phase, sclk SHALL return low and the FSM SHALL enter OUTPUT.
REQ-010 OUTPUT: data_out.valid SHALL assert at cycle T+2+conv_time+2*SAMPLE_WIDTH*(sclk_divider+1) and hold, with data stable, until valid and ready are both high on a clock edge; FSM then returns to IDLE, valid low the next cycle.
REQ-011 data_out.data SHALL be the sample in bits [SAMPLE_WIDTH-1:0], upper bits all equal to sample MSB if sign_extend=1, else zero.
REQ-012 sclk_divider, conv_time, sign_extend SHALL be latched at the IDLE->CONVERT transition; changes mid-conversion SHALL not affect the ongoing conversion.
REQ-013 trigger=1 in any state other than IDLE SHALL be ignored and SHALL produce overrun=1 for that single cycle; the ongoing conversion is unaffected.
REQ-014 trigger held high continuously SHALL start a new conversion on the first IDLE cycle after a handshake, with overrun pulsing on every non-IDLE cycle.
REQ-015 data_out.ready SHALL have no effect outside OUTPUT; ready held low SHALL stall indefinitely in OUTPUT with no data loss.
REQ-016 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-017 reset=0 SHALL immediately force state IDLE, cnv=0, sclk=0, data_out.valid=0, data_out.data=0, overrun=0, busy=0, shift register and counters 0.
REQ-018 reset asserted mid-conversion SHALL abort it with no output produced; first trigger after reset release SHALL start a fresh conversion.

Verification
REQ-019 Bench SHALL cover (SAMPLE_WIDTH=12, DATA_PATH_WIDTH=16):
 - div=0, conv_time=3, ready=1, miso pattern 0xA5C, sign_extend=1, trigger at T -> cnv high T+1..T+4, 12 sclk pulses period 2, valid at T+29, data 0xFA5C, one-cycle handshake.
 - same with sign_extend=0 -> data 0x0A5C; with div=2 -> sclk period 6, valid at T+77.
 - ready=0 for 20 cycles after valid -> valid and data held 20 cycles, handshake on ready rise, busy low next cycle.
 - extra trigger pulses during CONVERT, SHIFT, OUTPUT -> overrun pulse each, exactly one output sample.
 - reset=0 during SHIFT bit 6 -> all outputs zero at once, no valid; next trigger yields correct sample.
 - sclk_divider changed from 0 to 5 mid-SHIFT -> current conversion keeps period 2; next conversion uses period 12.
